audio_in_deserializer: RTL and testbench
========================================

AUDIO_IN_DESERIALIZER -- requirements
Module: audio_in_deserializer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 24, the number of codec bits captured per channel word (legal range 16..32).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, the number of stereo pairs buffered (power of two, at least 2).
REQ-003 The block SHALL have port CLOCK_50, input, 1 bit, the single system clock; every flop is clocked on its rising edge.
REQ-004 The block SHALL have port resetn, input, 1 bit, an asynchronous active-low reset.
REQ-005 The block SHALL have port AUD_BCLK, input, 1 bit, the codec bit clock, asynchronous to CLOCK_50.
REQ-006 The block SHALL have port AUD_ADCLRCK, input, 1 bit, the ADC frame clock (low = left, high = right), asynchronous.
REQ-007 The block SHALL have port AUD_ADCDAT, input, 1 bit, the ADC serial data, MSB first, asynchronous.
REQ-008 The block SHALL have port read_audio_in, input, 1 bit, which pops the head pair.
REQ-009 The block SHALL have port clear_audio_in_memory, input, 1 bit, a synchronous flush.
REQ-010 The block SHALL have port audio_in_available, output, 1 bit, meaning the FIFO is not empty.
REQ-011 The block SHALL have port left_channel_audio_in, output, 32 bits, the head left sample.
REQ-012 The block SHALL have port right_channel_audio_in, output, 32 bits, the head right sample.
REQ-013 The block SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits, the number of pairs held.
REQ-014 The block SHALL have port overflow, output, 1 bit, a sticky flag for dropped pairs.
REQ-015 The block SHALL have port frame_error, output, 1 bit, a sticky flag for aborted words.

Function
REQ-016 AUD_BCLK, AUD_ADCLRCK and AUD_ADCDAT SHALL each pass through a two-flop synchronizer; BCLK rising and LRCK edges are detected on the synchronized copies.
REQ-017 The FSM SHALL have the states WAIT_SYNC, L_DELAY, L_SHIFT, L_WAIT, R_DELAY, R_SHIFT and R_WAIT.
REQ-018 WAIT_SYNC SHALL go to L_DELAY on a synchronized LRCK falling edge and ignore all other activity.
REQ-019 The DELAY states SHALL consume exactly one BCLK rising edge, which is the I2S one-bit delay, and then enter the matching SHIFT state.
REQ-020 The SHIFT states SHALL sample ADCDAT on each BCLK rising edge into a shift register, MSB first, until DATA_WIDTH bits are taken, and then enter the matching WAIT state.
REQ-021 The WAIT states SHALL ignore further bits.
REQ-022 L_WAIT SHALL go to R_DELAY on an LRCK rising edge.
REQ-023 R_WAIT SHALL go to L_DELAY on an LRCK falling edge.
REQ-024 Each captured word SHALL be left-aligned: bits [31:32-DATA_WIDTH] hold the data and the lower bits are 0.
REQ-025 The stereo pair SHALL be pushed in the CLOCK_50 cycle after the DATA_WIDTH-th right bit is sampled.
REQ-026 audio_in_available and fifo_count SHALL reflect a push on the following cycle.
REQ-027 An LRCK edge during a DELAY or SHIFT state (short word) SHALL discard the partial pair, set frame_error and return the FSM to WAIT_SYNC.
REQ-028 The FIFO SHALL be show-ahead: while available=1 the outputs present the head pair, and while empty they are 0.
REQ-029 read_audio_in with available=1 SHALL pop the head pair at the clock edge.
REQ-030 read_audio_in with available=0 SHALL be ignored, with no underflow and no count change.
REQ-031 A push while full and not popping SHALL drop the new pair, set overflow and leave the contents unchanged.
REQ-032 A simultaneous push and pop while full SHALL succeed, and the count stays at FIFO_DEPTH.
REQ-033 A simultaneous push and pop while empty SHALL leave the pushed pair with count 1 (the pop is ignored).
REQ-034 The FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-035 clear_audio_in_memory SHALL take priority over push and pop, and on the next edge SHALL empty the FIFO, clear overflow and frame_error, and force WAIT_SYNC.

Reset
REQ-036 resetn=0 SHALL asynchronously set the FSM to WAIT_SYNC, clear the pointers, set count 0, available 0 and outputs 0, and clear overflow, frame_error, the synchronizers and the shift register.
REQ-037 A reset in the middle of a word SHALL lose the partial pair, and capture after release starts only at the next LRCK falling edge.

Verification
REQ-038 The bench SHALL cover the basic capture: DATA_WIDTH=24, BCLK=CLOCK_50/16, left=0x123456, right=0xABCDEF -> one pop yields 0x12345600 / 0xABCDEF00 and count returns to 0.
REQ-039 The bench SHALL cover start-up in mid-frame: release reset with LRCK high mid-right-word -> no pair is pushed until the first complete left+right pair after an LRCK falling edge.
REQ-040 The bench SHALL cover overflow: 5 frames with no reads, FIFO_DEPTH=4 -> count=4, overflow=1 and the head equals frame 1; 4 pops yield frames 1-4.
REQ-041 The bench SHALL cover a short word: toggle LRCK after 10 right bits -> frame_error=1, no push, and the next full frame is captured correctly.
REQ-042 The bench SHALL cover push and pop while full: read_audio_in held high during a push at count=4 -> count stays 4 and overflow stays 0.
REQ-043 The bench SHALL cover clear and pop-when-empty: clear_audio_in_memory at count=3 -> count=0, available=0 and flags 0 next cycle; read_audio_in while empty -> count stays 0.

Source files
------------

// File: rtl/audio_in_deserializer_if.sv
// Read-side bus of the I2S audio-in deserializer.
// slave: the deserializer; master: the sample consumer.
//   read_audio_in          pop head pair (consumer -> block)
//   clear_audio_in_memory  synchronous flush (consumer -> block)
//   audio_in_available     FIFO not empty
//   left/right_channel_audio_in  head pair, left-aligned, 0 when empty
//   fifo_count             pairs held
//   overflow, frame_error  sticky status flags
interface audio_in_deserializer_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          read_audio_in;
    logic          clear_audio_in_memory;
    logic          audio_in_available;
    logic [31:0]   left_channel_audio_in;
    logic [31:0]   right_channel_audio_in;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic          frame_error;

    modport master (
        output read_audio_in,
        output clear_audio_in_memory,
        input  audio_in_available,
        input  left_channel_audio_in,
        input  right_channel_audio_in,
        input  fifo_count,
        input  overflow,
        input  frame_error
    );

    modport slave (
        input  read_audio_in,
        input  clear_audio_in_memory,
        output audio_in_available,
        output left_channel_audio_in,
        output right_channel_audio_in,
        output fifo_count,
        output overflow,
        output frame_error
    );
endinterface

// File: rtl/audio_in_deserializer.sv
// I2S ADC capture into a show-ahead FIFO of stereo pairs.
// Ports: CLOCK_50 system clock, resetn async active-low reset,
//   AUD_BCLK/AUD_ADCLRCK/AUD_ADCDAT async codec pins,
//   bus (slave) read side: pop, flush, head pair, count, flags.
module audio_in_deserializer #(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         CLOCK_50,
    input  logic                         resetn,
    input  logic                         AUD_BCLK,
    input  logic                         AUD_ADCLRCK,
    input  logic                         AUD_ADCDAT,
    audio_in_deserializer_if.slave       bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        WAIT_SYNC,
        L_DELAY,
        L_SHIFT,
        L_WAIT,
        R_DELAY,
        R_SHIFT,
        R_WAIT
    } state_t;

    // Synchronizers plus one history flop for edge detection
    logic r_bclk_meta, r_bclk_sync, r_bclk_prev;
    logic r_lr_meta, r_lr_sync, r_lr_prev;
    logic r_dat_meta, r_dat_sync;

    logic w_bclk_rise, w_lr_rise, w_lr_fall, w_lr_edge;

    state_t r_state, w_state_nxt;
    logic   w_shift_en, w_cnt_clr, w_left_ld, w_push_set, w_abort;

    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_left;
    logic [5:0]            r_bit_cnt;
    logic                  r_push_pend;
    logic                  r_frame_err;

    logic [31:0]   r_mem_l [FIFO_DEPTH];
    logic [31:0]   r_mem_r [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    logic w_last_bit, w_full, w_empty, w_pop, w_do_push;
    logic [DATA_WIDTH+31:0] w_l_ext, w_r_ext;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_bclk_meta <= 1'b0;
            r_bclk_sync <= 1'b0;
            r_bclk_prev <= 1'b0;
            r_lr_meta   <= 1'b0;
            r_lr_sync   <= 1'b0;
            r_lr_prev   <= 1'b0;
            r_dat_meta  <= 1'b0;
            r_dat_sync  <= 1'b0;
        end else begin
            r_bclk_meta <= AUD_BCLK;
            r_bclk_sync <= r_bclk_meta;
            r_bclk_prev <= r_bclk_sync;
            r_lr_meta   <= AUD_ADCLRCK;
            r_lr_sync   <= r_lr_meta;
            r_lr_prev   <= r_lr_sync;
            r_dat_meta  <= AUD_ADCDAT;
            r_dat_sync  <= r_dat_meta;
        end
    end

    assign w_bclk_rise = r_bclk_sync & ~r_bclk_prev;
    assign w_lr_rise   = r_lr_sync & ~r_lr_prev;
    assign w_lr_fall   = ~r_lr_sync & r_lr_prev;
    assign w_lr_edge   = r_lr_sync ^ r_lr_prev;
    assign w_last_bit  = (r_bit_cnt == 6'(DATA_WIDTH - 1));

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state <= WAIT_SYNC;
        end else if (bus.clear_audio_in_memory) begin
            r_state <= WAIT_SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_en  = 1'b0;
        w_cnt_clr   = 1'b0;
        w_left_ld   = 1'b0;
        w_push_set  = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            WAIT_SYNC: begin
                if (w_lr_fall) begin
                    w_state_nxt = L_DELAY;
                    w_cnt_clr   = 1'b1;
                end
            end
            L_DELAY: begin
                if (w_lr_edge) begin
                    w_abort     = 1'b1;
                    w_state_nxt = WAIT_SYNC;
                end else if (w_bclk_rise) begin
                    w_state_nxt = L_SHIFT;
                end
            end
            L_SHIFT: begin
                if (w_lr_edge) begin
                    w_abort     = 1'b1;
                    w_state_nxt = WAIT_SYNC;
                end else if (w_bclk_rise) begin
                    w_shift_en = 1'b1;
                    if (w_last_bit) begin
                        w_left_ld   = 1'b1;
                        w_state_nxt = L_WAIT;
                    end
                end
            end
            L_WAIT: begin
                if (w_lr_rise) begin
                    w_state_nxt = R_DELAY;
                    w_cnt_clr   = 1'b1;
                end
            end
            R_DELAY: begin
                if (w_lr_edge) begin
                    w_abort     = 1'b1;
                    w_state_nxt = WAIT_SYNC;
                end else if (w_bclk_rise) begin
                    w_state_nxt = R_SHIFT;
                end
            end
            R_SHIFT: begin
                if (w_lr_edge) begin
                    w_abort     = 1'b1;
                    w_state_nxt = WAIT_SYNC;
                end else if (w_bclk_rise) begin
                    w_shift_en = 1'b1;
                    if (w_last_bit) begin
                        w_push_set  = 1'b1;
                        w_state_nxt = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (w_lr_fall) begin
                    w_state_nxt = L_DELAY;
                    w_cnt_clr   = 1'b1;
                end
            end
            default: w_state_nxt = WAIT_SYNC;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_shift     <= '0;
            r_left      <= '0;
            r_bit_cnt   <= '0;
            r_push_pend <= 1'b0;
            r_frame_err <= 1'b0;
        end else if (bus.clear_audio_in_memory) begin
            r_bit_cnt   <= '0;
            r_push_pend <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            // Push lands one cycle after the final right bit is shifted
            r_push_pend <= w_push_set;
            if (w_abort) r_frame_err <= 1'b1;
            if (w_cnt_clr) begin
                r_bit_cnt <= '0;
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + 6'd1;
            end
            if (w_shift_en) begin
                r_shift <= {r_shift[DATA_WIDTH-2:0], r_dat_sync};
            end
            if (w_left_ld) begin
                r_left <= {r_shift[DATA_WIDTH-2:0], r_dat_sync};
            end
        end
    end

    // Left-align each word; low bits fill with zeros
    assign w_l_ext = {r_left, 32'd0};
    assign w_r_ext = {r_shift, 32'd0};

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_pop     = bus.read_audio_in & ~w_empty;
    assign w_do_push = r_push_pend & (~w_full | w_pop);

    always_ff @(posedge CLOCK_50) begin
        if (w_do_push && !bus.clear_audio_in_memory) begin
            r_mem_l[r_wr_ptr] <= w_l_ext[DATA_WIDTH+31 -: 32];
            r_mem_r[r_wr_ptr] <= w_r_ext[DATA_WIDTH+31 -: 32];
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (bus.clear_audio_in_memory) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (r_push_pend && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    assign bus.audio_in_available     = ~w_empty;
    assign bus.left_channel_audio_in  = w_empty ? 32'd0 : r_mem_l[r_rd_ptr];
    assign bus.right_channel_audio_in = w_empty ? 32'd0 : r_mem_r[r_rd_ptr];
    assign bus.fifo_count             = r_count;
    assign bus.overflow               = r_overflow;
    assign bus.frame_error            = r_frame_err;
endmodule

// File: tb/tb_audio_in_deserializer.sv
// Directed bench for audio_in_deserializer: I2S frames at
// BCLK = CLOCK_50/16, 32 slots per channel, 24-bit words.
module tb_audio_in_deserializer;
    logic CLOCK_50 = 1'b0;
    logic resetn;
    logic AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT;

    audio_in_deserializer_if #(.FIFO_DEPTH(4)) bus ();

    audio_in_deserializer #(
        .DATA_WIDTH(24),
        .FIFO_DEPTH(4)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .resetn     (resetn),
        .AUD_BCLK   (AUD_BCLK),
        .AUD_ADCLRCK(AUD_ADCLRCK),
        .AUD_ADCDAT (AUD_ADCDAT),
        .bus        (bus)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int checks   = 0;
    int failures = 0;
    int minc, maxc;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        logic [31:0] el;
        logic [31:0] er;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One BCLK period; data and LRCK change while BCLK is low.
    // With hook set, read_audio_in is pulsed for exactly the
    // CLOCK_50 edge on which the resulting push lands, and the
    // count is tracked across the high half.
    task automatic send_bit(input logic lr, input logic d, input bit hook);
        @(negedge CLOCK_50);
        AUD_BCLK    = 1'b0;
        AUD_ADCLRCK = lr;
        AUD_ADCDAT  = d;
        repeat (8) @(negedge CLOCK_50);
        AUD_BCLK = 1'b1;
        if (hook) begin
            minc = 99;
            maxc = 0;
        end
        for (int k = 1; k <= 7; k++) begin
            @(negedge CLOCK_50);
            if (hook) begin
                if (int'(bus.fifo_count) < minc) minc = int'(bus.fifo_count);
                if (int'(bus.fifo_count) > maxc) maxc = int'(bus.fifo_count);
                if (k == 3) bus.read_audio_in = 1'b1;
                if (k == 4) bus.read_audio_in = 1'b0;
            end
        end
    endtask

    // Slot 0 is the I2S delay bit (driven opposite to the MSB),
    // slots 1..24 carry the word, trailing slots are 1.
    task automatic send_word(input logic lr, input logic [23:0] w,
                             input int slots, input bit hook);
        logic d;
        for (int s = 0; s < slots; s++) begin
            if (s == 0) d = ~w[23];
            else if (s <= 24) d = w[24-s];
            else d = 1'b1;
            send_bit(lr, d, hook && (s == 24));
        end
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r,
                              input bit hook);
        send_word(1'b0, l, 32, 1'b0);
        send_word(1'b1, r, 32, hook);
    endtask

    task automatic pop();
        @(negedge CLOCK_50);
        bus.read_audio_in = 1'b1;
        @(negedge CLOCK_50);
        bus.read_audio_in = 1'b0;
    endtask

    task automatic clear_fifo();
        @(negedge CLOCK_50);
        bus.clear_audio_in_memory = 1'b1;
        @(negedge CLOCK_50);
        bus.clear_audio_in_memory = 1'b0;
    endtask

    function automatic logic [23:0] fl(input int k);
        return {8'(8'h10 + k), 16'h5A5A};
    endfunction

    function automatic logic [23:0] fr(input int k);
        return {8'(8'h20 + k), 16'hC3C3};
    endfunction

    initial begin
        vecs[0] = '{24'h123456, 24'hABCDEF, 32'h12345600, 32'hABCDEF00};
        vecs[1] = '{24'hFFFFFF, 24'h000000, 32'hFFFFFF00, 32'h00000000};
        vecs[2] = '{24'h800001, 24'h7FFFFE, 32'h80000100, 32'h7FFFFE00};
        vecs[3] = '{24'h5A5A5A, 24'hA5A5A5, 32'h5A5A5A00, 32'hA5A5A500};

        resetn      = 1'b0;
        AUD_BCLK    = 1'b0;
        AUD_ADCLRCK = 1'b1;
        AUD_ADCDAT  = 1'b0;
        bus.read_audio_in         = 1'b0;
        bus.clear_audio_in_memory = 1'b0;

        repeat (4) @(negedge CLOCK_50);
        chk("rst_avail", 32'(bus.audio_in_available), 32'd0);
        chk("rst_count", 32'(bus.fifo_count), 32'd0);
        chk("rst_left", bus.left_channel_audio_in, 32'd0);
        chk("rst_right", bus.right_channel_audio_in, 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        chk("rst_ferr", 32'(bus.frame_error), 32'd0);
        resetn = 1'b1;
        repeat (4) @(negedge CLOCK_50);

        // Basic capture table
        for (int i = 0; i < 4; i++) begin
            send_frame(vecs[i].l, vecs[i].r, 1'b0);
            chk($sformatf("v%0d_count", i), 32'(bus.fifo_count), 32'd1);
            chk($sformatf("v%0d_avail", i), 32'(bus.audio_in_available), 32'd1);
            chk($sformatf("v%0d_left", i), bus.left_channel_audio_in, vecs[i].el);
            chk($sformatf("v%0d_right", i), bus.right_channel_audio_in, vecs[i].er);
            pop();
            chk($sformatf("v%0d_cnt0", i), 32'(bus.fifo_count), 32'd0);
            chk($sformatf("v%0d_left0", i), bus.left_channel_audio_in, 32'd0);
        end

        // Reset released in the middle of a right word
        @(negedge CLOCK_50);
        resetn = 1'b0;
        for (int s = 0; s < 12; s++) send_bit(1'b1, s[0], 1'b0);
        resetn = 1'b1;
        for (int s = 0; s < 20; s++) send_bit(1'b1, ~s[0], 1'b0);
        chk("mid_count", 32'(bus.fifo_count), 32'd0);
        send_frame(24'h13579B, 24'h2468AC, 1'b0);
        chk("mid_count1", 32'(bus.fifo_count), 32'd1);
        chk("mid_left", bus.left_channel_audio_in, 32'h13579B00);
        chk("mid_right", bus.right_channel_audio_in, 32'h2468AC00);
        pop();

        // Overflow: five frames, no reads
        for (int k = 1; k <= 5; k++) send_frame(fl(k), fr(k), 1'b0);
        chk("ovf_count", 32'(bus.fifo_count), 32'd4);
        chk("ovf_flag", 32'(bus.overflow), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("ovf_l%0d", k), bus.left_channel_audio_in, {fl(k), 8'h00});
            chk($sformatf("ovf_r%0d", k), bus.right_channel_audio_in, {fr(k), 8'h00});
            pop();
        end
        chk("ovf_cnt0", 32'(bus.fifo_count), 32'd0);

        // Short right word: LRCK falls after 10 right bits
        send_word(1'b0, 24'h111111, 32, 1'b0);
        send_word(1'b1, 24'h222222, 11, 1'b0);
        send_word(1'b0, 24'h333333, 32, 1'b0);
        send_word(1'b1, 24'h444444, 32, 1'b0);
        chk("short_ferr", 32'(bus.frame_error), 32'd1);
        chk("short_count", 32'(bus.fifo_count), 32'd0);
        send_frame(24'hC0FFEE, 24'hBADA55, 1'b0);
        chk("short_cnt1", 32'(bus.fifo_count), 32'd1);
        chk("short_left", bus.left_channel_audio_in, 32'hC0FFEE00);
        chk("short_right", bus.right_channel_audio_in, 32'hBADA5500);
        chk("short_sticky", 32'(bus.frame_error), 32'd1);

        // Clear at count 3, then pop while empty
        send_frame(fl(6), fr(6), 1'b0);
        send_frame(fl(7), fr(7), 1'b0);
        chk("clr_pre", 32'(bus.fifo_count), 32'd3);
        clear_fifo();
        chk("clr_count", 32'(bus.fifo_count), 32'd0);
        chk("clr_avail", 32'(bus.audio_in_available), 32'd0);
        chk("clr_ovf", 32'(bus.overflow), 32'd0);
        chk("clr_ferr", 32'(bus.frame_error), 32'd0);
        chk("clr_left", bus.left_channel_audio_in, 32'd0);
        pop();
        chk("empty_pop", 32'(bus.fifo_count), 32'd0);
        chk("empty_avail", 32'(bus.audio_in_available), 32'd0);

        // Push and pop together while full
        for (int k = 1; k <= 4; k++) send_frame(fl(k), fr(k), 1'b0);
        chk("full_pre", 32'(bus.fifo_count), 32'd4);
        send_frame(fl(5), fr(5), 1'b1);
        chk("full_min", 32'(minc), 32'd4);
        chk("full_max", 32'(maxc), 32'd4);
        chk("full_count", 32'(bus.fifo_count), 32'd4);
        chk("full_ovf", 32'(bus.overflow), 32'd0);
        for (int k = 2; k <= 5; k++) begin
            chk($sformatf("full_l%0d", k), bus.left_channel_audio_in, {fl(k), 8'h00});
            chk($sformatf("full_r%0d", k), bus.right_channel_audio_in, {fr(k), 8'h00});
            pop();
        end
        chk("full_cnt0", 32'(bus.fifo_count), 32'd0);

        // Push and pop together while empty: pop ignored
        send_frame(24'h0F0F0F, 24'hF0F0F0, 1'b1);
        chk("pe_count", 32'(bus.fifo_count), 32'd1);
        chk("pe_left", bus.left_channel_audio_in, 32'h0F0F0F00);
        chk("pe_right", bus.right_channel_audio_in, 32'hF0F0F000);
        pop();
        chk("pe_cnt0", 32'(bus.fifo_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
